// File: rtl/ftl_buf_ring.sv
// Ring of page slots shared by the wishbone producer and ftl_physical consumer.
// Ownership passes producer->consumer on commit and back on release.
module ftl_buf_ring #(
    parameter int DATA_W  = 32,
    parameter int PAGE_AW = 10,
    parameter int SLOT_AW = 2
) (
    input  logic               clk_50,
    input  logic               reset_n,
    output logic               prod_avail,
    output logic [SLOT_AW-1:0] prod_slot,
    input  logic [PAGE_AW-1:0] prod_addr,
    input  logic               prod_wren,
    input  logic [DATA_W-1:0]  prod_data,
    output logic [DATA_W-1:0]  prod_q,
    input  logic               prod_commit,
    output logic               cons_avail,
    output logic [SLOT_AW-1:0] cons_slot,
    input  logic [PAGE_AW-1:0] cons_addr,
    input  logic               cons_wren,
    input  logic [DATA_W-1:0]  cons_data,
    output logic [DATA_W-1:0]  cons_q,
    input  logic               cons_release,
    output logic [SLOT_AW:0]   count,
    output logic               err_overrun,
    output logic               err_underrun,
    input  logic               err_clr
);
    localparam int              RAM_AW = SLOT_AW + PAGE_AW;
    localparam logic [SLOT_AW:0] FULL  = (SLOT_AW+1)'(2**SLOT_AW);

    logic [SLOT_AW-1:0] wr_ptr, rd_ptr;
    logic [SLOT_AW:0]   count_nxt;
    logic               commit_ok, release_ok;
    logic               overrun_evt, underrun_evt;
    logic [RAM_AW-1:0]  prod_ram_addr, cons_ram_addr;
    logic [DATA_W-1:0]  mem [2**RAM_AW];

    assign prod_slot     = wr_ptr;
    assign cons_slot     = rd_ptr;
    assign prod_ram_addr = {wr_ptr, prod_addr};
    assign cons_ram_addr = {rd_ptr, cons_addr};

    // prod_avail/cons_avail are the registered view of count, so they gate this edge
    assign commit_ok    = prod_commit  && prod_avail;
    assign release_ok   = cons_release && cons_avail;
    assign overrun_evt  = (prod_commit  || prod_wren) && !prod_avail;
    assign underrun_evt = (cons_release || cons_wren) && !cons_avail;

    always_comb begin
        count_nxt = count;
        if (commit_ok && !release_ok)
            count_nxt = count + (SLOT_AW+1)'(1);
        else if (!commit_ok && release_ok)
            count_nxt = count - (SLOT_AW+1)'(1);
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            prod_avail <= 1'b1;
            cons_avail <= 1'b0;
        end else begin
            if (commit_ok)  wr_ptr <= wr_ptr + SLOT_AW'(1);
            if (release_ok) rd_ptr <= rd_ptr + SLOT_AW'(1);
            count      <= count_nxt;
            prod_avail <= (count_nxt != FULL);
            cons_avail <= (count_nxt != '0);
        end
    end

    // Clear wins over a coincident error event
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            err_overrun  <= 1'b0;
            err_underrun <= 1'b0;
        end else begin
            if (err_clr)          err_overrun  <= 1'b0;
            else if (overrun_evt) err_overrun  <= 1'b1;
            if (err_clr)           err_underrun <= 1'b0;
            else if (underrun_evt) err_underrun <= 1'b1;
        end
    end

    // Ring pointers never coincide while both sides own a slot, so the two
    // write ports cannot hit the same word.
    always_ff @(posedge clk_50) begin
        if (prod_wren && prod_avail) mem[prod_ram_addr] <= prod_data;
        if (cons_wren && cons_avail) mem[cons_ram_addr] <= cons_data;
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            prod_q <= '0;
            cons_q <= '0;
        end else begin
            prod_q <= mem[prod_ram_addr];
            cons_q <= mem[cons_ram_addr];
        end
    end
endmodule

// File: tb/tb_ftl_buf_ring.sv
// Directed-plus-random bench for ftl_buf_ring against a slot/queue level model.
module tb_ftl_buf_ring;
    localparam int DATA_W  = 32;
    localparam int PAGE_AW = 10;
    localparam int SLOT_AW = 2;
    localparam int SLOTS   = 1 << SLOT_AW;
    localparam int PAGE    = 1 << PAGE_AW;

    logic               clk_50 = 1'b0;
    logic               reset_n = 1'b0;
    logic               prod_avail, cons_avail, err_overrun, err_underrun;
    logic [SLOT_AW-1:0] prod_slot, cons_slot;
    logic [PAGE_AW-1:0] prod_addr = '0, cons_addr = '0;
    logic               prod_wren = 0, prod_commit = 0, cons_wren = 0, cons_release = 0, err_clr = 0;
    logic [DATA_W-1:0]  prod_data = '0, cons_data = '0, prod_q, cons_q;
    logic [SLOT_AW:0]   count;

    int vectors = 0, miscompares = 0;

    // Reference model: per-slot page storage plus ring bookkeeping as plain integers
    logic [DATA_W-1:0] mem_m [SLOTS][PAGE];
    bit                known [SLOTS][PAGE];
    int                m_wr, m_rd, m_count;
    bit                m_ovr, m_und, m_pq_ok, m_cq_ok;
    logic [DATA_W-1:0] m_pq, m_cq;

    ftl_buf_ring #(.DATA_W(DATA_W), .PAGE_AW(PAGE_AW), .SLOT_AW(SLOT_AW)) dut (
        .clk_50(clk_50), .reset_n(reset_n),
        .prod_avail(prod_avail), .prod_slot(prod_slot), .prod_addr(prod_addr),
        .prod_wren(prod_wren), .prod_data(prod_data), .prod_q(prod_q), .prod_commit(prod_commit),
        .cons_avail(cons_avail), .cons_slot(cons_slot), .cons_addr(cons_addr),
        .cons_wren(cons_wren), .cons_data(cons_data), .cons_q(cons_q), .cons_release(cons_release),
        .count(count), .err_overrun(err_overrun), .err_underrun(err_underrun), .err_clr(err_clr)
    );

    always #5 clk_50 = ~clk_50;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".count"},      64'(count),        64'(m_count));
        chk({tag, ".prod_avail"}, 64'(prod_avail),   64'(m_count < SLOTS));
        chk({tag, ".cons_avail"}, 64'(cons_avail),   64'(m_count > 0));
        chk({tag, ".prod_slot"},  64'(prod_slot),    64'(m_wr));
        chk({tag, ".cons_slot"},  64'(cons_slot),    64'(m_rd));
        chk({tag, ".overrun"},    64'(err_overrun),  64'(m_ovr));
        chk({tag, ".underrun"},   64'(err_underrun), 64'(m_und));
        if (m_pq_ok) chk({tag, ".prod_q"}, 64'(prod_q), 64'(m_pq));
        if (m_cq_ok) chk({tag, ".cons_q"}, 64'(cons_q), 64'(m_cq));
    endtask

    task automatic model_reset();
        m_wr = 0; m_rd = 0; m_count = 0; m_ovr = 0; m_und = 0;
        m_pq = '0; m_cq = '0; m_pq_ok = 1; m_cq_ok = 1;
    endtask

    // Apply the currently driven inputs for one edge, advance the model, check, then idle.
    task automatic tick(string tag);
        bit p_ok, c_ok;
        p_ok = m_count < SLOTS;
        c_ok = m_count > 0;
        m_pq = mem_m[m_wr][prod_addr]; m_pq_ok = known[m_wr][prod_addr];
        m_cq = mem_m[m_rd][cons_addr]; m_cq_ok = known[m_rd][cons_addr];
        if (prod_wren && p_ok) begin mem_m[m_wr][prod_addr] = prod_data; known[m_wr][prod_addr] = 1; end
        if (cons_wren && c_ok) begin mem_m[m_rd][cons_addr] = cons_data; known[m_rd][cons_addr] = 1; end
        if (err_clr) m_ovr = 0; else if ((prod_commit || prod_wren) && !p_ok) m_ovr = 1;
        if (err_clr) m_und = 0; else if ((cons_release || cons_wren) && !c_ok) m_und = 1;
        if (prod_commit && p_ok)  begin m_wr = (m_wr + 1) % SLOTS; m_count++; end
        if (cons_release && c_ok) begin m_rd = (m_rd + 1) % SLOTS; m_count--; end
        @(posedge clk_50); #1;
        check_all(tag);
        prod_wren = 0; prod_commit = 0; cons_wren = 0; cons_release = 0; err_clr = 0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk_50);
        #1;
        check_all("reset");
        reset_n = 1;

        // Fill slot 0 with an offset pattern and hand it over
        for (int i = 0; i < PAGE; i++) begin
            prod_addr = PAGE_AW'(i); prod_data = 32'hA5A5_0000 + 32'(i); prod_wren = 1;
            tick("fill0");
        end
        prod_commit = 1; tick("commit0");
        chk("c0.count", 64'(count), 64'd1);
        chk("c0.cons_slot", 64'(cons_slot), 64'd0);
        chk("c0.prod_slot", 64'(prod_slot), 64'd1);
        cons_addr = 5; tick("read5");
        chk("read5.cons_q", 64'(cons_q), 64'hA5A5_0005);

        // Fill to full, then overrun on an extra commit
        for (int k = 0; k < 3; k++) begin prod_commit = 1; tick("commit_more"); end
        chk("full.count", 64'(count), 64'd4);
        chk("full.prod_avail", 64'(prod_avail), 64'd0);
        prod_commit = 1; tick("commit_over");
        chk("over.flag", 64'(err_overrun), 64'd1);
        chk("over.wr_ptr", 64'(prod_slot), 64'd0);
        prod_wren = 1; prod_data = $urandom; prod_addr = PAGE_AW'($urandom_range(0, PAGE-1));
        tick("write_over");
        err_clr = 1; tick("clr_over");
        chk("clr.overrun", 64'(err_overrun), 64'd0);

        // Drain back to empty, then underrun and a dropped consumer write
        for (int k = 0; k < SLOTS; k++) begin
            cons_addr = PAGE_AW'($urandom_range(0, PAGE-1)); cons_release = 1; tick("release_all");
        end
        cons_release = 1; tick("release_under");
        chk("under.count", 64'(count), 64'd0);
        chk("under.flag", 64'(err_underrun), 64'd1);
        cons_release = 1; err_clr = 1; tick("clr_beats_event");
        cons_addr = 0; cons_wren = 1; cons_data = $urandom; tick("cwrite_dropped");
        tick("readback0");
        chk("dropped.cons_q", 64'(cons_q), 64'hA5A5_0000);
        err_clr = 1; tick("clr_under");

        // Simultaneous commit/release at count=2 and at count=0
        for (int k = 0; k < 2; k++) begin prod_commit = 1; tick("commit2"); end
        prod_commit = 1; cons_release = 1; tick("both_at2");
        chk("both2.count", 64'(count), 64'd2);
        chk("both2.wr", 64'(prod_slot), 64'd3);
        chk("both2.rd", 64'(cons_slot), 64'd1);
        for (int k = 0; k < 2; k++) begin cons_release = 1; tick("release2"); end
        prod_commit = 1; cons_release = 1; tick("both_at0");
        chk("both0.count", 64'(count), 64'd1);
        chk("both0.underrun", 64'(err_underrun), 64'd1);
        err_clr = 1; cons_release = 1; tick("back_to_empty");

        // Nine full fill/drain laps with slot-tagged data so both pointers wrap
        for (int lap = 0; lap < 9; lap++) begin
            for (int i = 0; i < PAGE; i++) begin
                prod_addr = PAGE_AW'(i); prod_data = 32'h5107_0000 | 32'(m_wr); prod_wren = 1;
                tick("wrap_fill");
            end
            prod_commit = 1; tick("wrap_commit");
            for (int i = 0; i < PAGE; i++) begin
                cons_addr = PAGE_AW'(i); tick("wrap_drain");
            end
            cons_release = 1; tick("wrap_release");
        end

        // Asynchronous reset in the middle of filling the fourth slot
        for (int k = 0; k < 3; k++) begin prod_commit = 1; tick("pre_reset_commit"); end
        for (int i = 0; i < 16; i++) begin
            prod_addr = PAGE_AW'($urandom_range(0, PAGE-1)); prod_data = $urandom; prod_wren = 1;
            cons_addr = PAGE_AW'($urandom_range(0, PAGE-1));
            tick("mid_fill");
        end
        #2 reset_n = 0;
        #1;
        model_reset();
        check_all("async_reset");
        chk("areset.prod_q", 64'(prod_q), 64'd0);
        chk("areset.cons_q", 64'(cons_q), 64'd0);
        @(negedge clk_50);
        reset_n = 1;
        tick("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
